// File: rtl/max7219_pkg.sv
// Shared constants for the MAX7219 display controller.
// Holds the device register addresses, the init-sequence data constants,
// the controller FSM state encoding and a frame-packing helper.
package max7219_pkg;

  // MAX7219 register addresses; only the low nibble travels in a frame.
  localparam logic [3:0] REG_DECODE    = 4'h9;
  localparam logic [3:0] REG_INTENSITY = 4'hA;
  localparam logic [3:0] REG_SCAN      = 4'hB;
  localparam logic [3:0] REG_SHUTDOWN  = 4'hC;
  localparam logic [3:0] REG_TEST      = 4'hF;

  // Data written during the init sequence.
  localparam logic [7:0] SHUTDOWN_OFF = 8'h01;  // normal operation
  localparam logic [7:0] TEST_OFF     = 8'h00;  // display test disabled

  // Number of frames in the init sequence.
  localparam logic [2:0] INIT_STEPS = 3'd5;

  typedef enum logic [2:0] {
    INIT_SEL,
    IDLE,
    CS_LOW,
    SEND_HI,
    WAIT_HI,
    SEND_LO,
    WAIT_LO,
    CS_HIGH
  } state_e;

  // 16-bit frame: {don't-care nibble, register address, data}.
  function automatic logic [15:0] mk_frame(input logic [3:0] addr, input logic [7:0] data);
    return {4'h0, addr, data};
  endfunction

endpackage

// File: rtl/max7219_ctrl_if.sv
// Host/device bundle for the MAX7219 controller.
//   wr_en/wr_addr/wr_data : digit buffer write port (host -> controller)
//   intensity             : brightness level, sampled continuously
//   refresh               : pulse that marks every digit for resend
//   mosi/sck/cs_n         : serial lines toward the MAX7219
//   init_done/busy        : controller status
// master = host side, slave = controller side.
interface max7219_ctrl_if;
  logic       wr_en;
  logic [2:0] wr_addr;
  logic [7:0] wr_data;
  logic [3:0] intensity;
  logic       refresh;
  logic       mosi;
  logic       sck;
  logic       cs_n;
  logic       init_done;
  logic       busy;

  modport master (
    output wr_en, wr_addr, wr_data, intensity, refresh,
    input  mosi, sck, cs_n, init_done, busy
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, intensity, refresh,
    output mosi, sck, cs_n, init_done, busy
  );
endinterface

// File: rtl/max7219_ctrl_spi_master.sv
// Byte engine: shifts one byte out MSB first, two clk cycles per bit
// (sck low with mosi set up, then sck high for the device to sample).
//   clk, rst    : clock, synchronous active-high reset
//   start_i     : one-cycle start, accepted only while idle
//   data_in_i   : byte to send, sampled with start_i
//   new_data_o  : one-cycle pulse once the last bit has been clocked
//   sck_o       : serial clock, low whenever idle
//   mosi_o      : serial data, holds its last value while idle
module spi_master (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_i,
  input  logic [7:0] data_in_i,
  output logic       new_data_o,
  output logic       sck_o,
  output logic       mosi_o
);

  logic       act_q, act_d;
  logic       ph_q, ph_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] sh_q, sh_d;
  logic       done_q, done_d;

  always_comb begin
    act_d  = act_q;
    ph_d   = ph_q;
    cnt_d  = cnt_q;
    sh_d   = sh_q;
    done_d = 1'b0;
    if (!act_q) begin
      if (start_i) begin
        act_d = 1'b1;
        ph_d  = 1'b0;
        cnt_d = 3'd7;
        sh_d  = data_in_i;
      end
    end else if (!ph_q) begin
      ph_d = 1'b1;
    end else begin
      ph_d = 1'b0;
      if (cnt_q == 3'd0) begin
        act_d  = 1'b0;
        done_d = 1'b1;
      end else begin
        cnt_d = cnt_q - 3'd1;
        // No shift after the last bit, so mosi does not move once idle.
        sh_d  = {sh_q[6:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      act_q  <= 1'b0;
      ph_q   <= 1'b0;
      cnt_q  <= 3'd0;
      sh_q   <= 8'h00;
      done_q <= 1'b0;
    end else begin
      act_q  <= act_d;
      ph_q   <= ph_d;
      cnt_q  <= cnt_d;
      sh_q   <= sh_d;
      done_q <= done_d;
    end
  end

  assign sck_o      = act_q & ph_q;
  assign mosi_o     = sh_q[7];
  assign new_data_o = done_q;

endmodule

// File: rtl/max7219_ctrl.sv
// MAX7219 display controller. After reset it sends the five-frame init
// sequence, then keeps an 8-digit buffer in sync with the device, resending
// intensity whenever it differs from the last value sent.
//   clk, rst : clock, synchronous active-high reset
//   dev      : max7219_ctrl_if.slave (write port, intensity, refresh,
//              serial lines, init_done, busy)
module max7219_ctrl
  import max7219_pkg::*;
#(
  parameter logic [7:0]  DECODE_MODE = 8'h00,
  parameter logic [2:0]  SCAN_LIMIT  = 3'd7,
  parameter int unsigned CS_HOLD     = 4
) (
  input logic            clk,
  input logic            rst,
  max7219_ctrl_if.slave  dev
);

  localparam logic [7:0] HOLD_LAST = 8'(CS_HOLD - 1);

  state_e      state_q, state_d;
  logic [2:0]  step_q, step_d;
  logic        init_done_q, init_done_d;
  logic [15:0] frame_q, frame_d;
  logic [7:0]  hold_q, hold_d;
  logic [3:0]  last_int_q, last_int_d;
  logic [7:0]  digit_q [8];
  logic [7:0]  dirty_q, dirty_d, dirty_clr, dirty_set;
  logic        cs_n_q, busy_q;
  logic        frame_active_d;
  logic [2:0]  sel_idx;
  logic        sel_vld;
  logic        spi_start, spi_done, spi_sck, spi_mosi;
  logic [7:0]  spi_data;

  // Lowest-index dirty digit wins.
  always_comb begin
    sel_idx = 3'd0;
    sel_vld = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      if (dirty_q[i]) begin
        sel_idx = 3'(i);
        sel_vld = 1'b1;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    step_d      = step_q;
    init_done_d = init_done_q;
    frame_d     = frame_q;
    hold_d      = hold_q;
    last_int_d  = last_int_q;
    dirty_clr   = 8'h00;
    spi_start   = 1'b0;
    spi_data    = frame_q[15:8];
    case (state_q)
      INIT_SEL: begin
        case (step_q)
          3'd0:    frame_d = mk_frame(REG_SHUTDOWN, SHUTDOWN_OFF);
          3'd1:    frame_d = mk_frame(REG_TEST, TEST_OFF);
          3'd2:    frame_d = mk_frame(REG_DECODE, DECODE_MODE);
          3'd3:    frame_d = mk_frame(REG_SCAN, {5'b0, SCAN_LIMIT});
          default: begin
            frame_d    = mk_frame(REG_INTENSITY, {4'h0, dev.intensity});
            last_int_d = dev.intensity;
          end
        endcase
        step_d  = step_q + 3'd1;
        state_d = CS_LOW;
      end
      IDLE: begin
        if (dev.intensity != last_int_q) begin
          frame_d    = mk_frame(REG_INTENSITY, {4'h0, dev.intensity});
          last_int_d = dev.intensity;
          state_d    = CS_LOW;
        end else if (sel_vld) begin
          // Digit n lives at device address n+1.
          frame_d            = mk_frame({1'b0, sel_idx} + 4'd1, digit_q[sel_idx]);
          dirty_clr[sel_idx] = 1'b1;
          state_d            = CS_LOW;
        end
      end
      CS_LOW:  state_d = SEND_HI;
      SEND_HI: begin
        spi_start = 1'b1;
        spi_data  = frame_q[15:8];
        state_d   = WAIT_HI;
      end
      WAIT_HI: if (spi_done) state_d = SEND_LO;
      SEND_LO: begin
        spi_start = 1'b1;
        spi_data  = frame_q[7:0];
        state_d   = WAIT_LO;
      end
      WAIT_LO: begin
        if (spi_done) begin
          hold_d  = 8'd0;
          state_d = CS_HIGH;
        end
      end
      CS_HIGH: begin
        hold_d = hold_q + 8'd1;
        if (hold_q == HOLD_LAST) begin
          hold_d = 8'd0;
          if (init_done_q) begin
            state_d = IDLE;
          end else if (step_q == INIT_STEPS) begin
            init_done_d = 1'b1;
            state_d     = IDLE;
          end else begin
            state_d = INIT_SEL;
          end
        end
      end
      default: state_d = INIT_SEL;
    endcase
  end

  // A new write or refresh overrides a clear landing in the same cycle.
  always_comb begin
    dirty_set = {8{dev.refresh}};
    if (dev.wr_en) dirty_set[dev.wr_addr] = 1'b1;
    dirty_d = (dirty_q & ~dirty_clr) | dirty_set;
  end

  assign frame_active_d = (state_d == CS_LOW) || (state_d == SEND_HI) || (state_d == WAIT_HI) ||
                          (state_d == SEND_LO) || (state_d == WAIT_LO);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= INIT_SEL;
      step_q      <= 3'd0;
      init_done_q <= 1'b0;
      hold_q      <= 8'd0;
      last_int_q  <= 4'h0;
      dirty_q     <= 8'hFF;
      cs_n_q      <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      init_done_q <= init_done_d;
      hold_q      <= hold_d;
      last_int_q  <= last_int_d;
      dirty_q     <= dirty_d;
      cs_n_q      <= ~frame_active_d;
      busy_q      <= frame_active_d || (state_d == CS_HIGH);
    end
  end

  always_ff @(posedge clk) begin
    frame_q <= frame_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) digit_q[i] <= 8'h00;
    end else if (dev.wr_en) begin
      digit_q[dev.wr_addr] <= dev.wr_data;
    end
  end

  spi_master u_spi (
    .clk        (clk),
    .rst        (rst),
    .start_i    (spi_start),
    .data_in_i  (spi_data),
    .new_data_o (spi_done),
    .sck_o      (spi_sck),
    .mosi_o     (spi_mosi)
  );

  assign dev.sck       = spi_sck;
  assign dev.mosi      = spi_mosi;
  assign dev.cs_n      = cs_n_q;
  assign dev.busy      = busy_q;
  assign dev.init_done = init_done_q;

endmodule

// File: doc/max7219_ctrl.md
MAX7219_CTRL -- requirements
Module: max7219_ctrl

Interface
REQ-001 SHALL have parameter DECODE_MODE, default 8'h00, value written to MAX7219 register 0x09.
REQ-002 SHALL have parameter SCAN_LIMIT, default 3'd7, value written to register 0x0B.
REQ-003 SHALL have parameter CS_HOLD, default 4, the number of clk cycles cs_n stays high between frames (min 2).
REQ-004 clk  in  1  system clock.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 wr_en  in  1  digit buffer write strobe.
REQ-007 wr_addr  in  3  digit index 0..7.
REQ-008 wr_data  in  8  digit segment/code byte.
REQ-009 intensity  in  4  brightness for register 0x0A; sampled continuously.
REQ-010 refresh  in  1  pulse; marks all digits for resend.
REQ-011 mosi  out  1  serial data to MAX7219 DIN.
REQ-012 sck  out  1  serial clock to MAX7219 CLK.
REQ-013 cs_n  out  1  MAX7219 LOAD/CS; low during a frame.
REQ-014 init_done  out  1  high once the init sequence has completed.
REQ-015 busy  out  1  high while a frame is in progress (cs_n low or in hold).

Function
REQ-016 Frame SHALL be 16 bits {4'h0, addr[3:0], data[7:0]}, MSB first, sent as two bytes (high, then low) via the byte engine.
REQ-017 Byte engine handshake: one-cycle start with the byte on data_in while it is idle; byte complete on its new_data pulse; next start no earlier than the cycle after new_data.
REQ-018 FSM states SHALL be: INIT_SEL, IDLE, CS_LOW, SEND_HI, WAIT_HI, SEND_LO, WAIT_LO, CS_HIGH.
REQ-019 CS_LOW: cs_n driven low for one cycle before SEND_HI; cs_n SHALL stay low until the WAIT_LO new_data; CS_HIGH holds cs_n high for CS_HOLD cycles, then returns to INIT_SEL (init not done) or IDLE.
REQ-020 Init sequence, in order: 0x0C01 (shutdown off), 0x0F00 (test off), 0x09/DECODE_MODE, 0x0B/{5'b0,SCAN_LIMIT}, 0x0A/{4'b0,intensity}; init_done rises on the cycle CS_HIGH ends after the fifth frame.
REQ-021 Digit buffer: 8x8 registers; wr_en writes wr_data to wr_addr and sets dirty[wr_addr] on the next edge, in any state.
REQ-022 IDLE selection priority: intensity differs from last-sent value > lowest-index dirty digit; none pending -> stay IDLE.
REQ-023 Digit n SHALL use address n+1 (0x01..0x08); frame data and dirty clear SHALL be captured at the IDLE->CS_LOW transition.
REQ-024 wr_en to a digit in the same cycle its dirty bit clears: set wins; the digit is resent with the new value.
REQ-025 refresh SHALL set all 8 dirty bits; coincident with a clear, set wins.
REQ-026 Intensity changes during a frame SHALL take effect in a subsequent frame; the last-sent intensity register updates at capture.
REQ-027 sck SHALL be low and mosi stable whenever cs_n is high.

Reset
REQ-028 On rst: state INIT_SEL, init step 0, cs_n=1, init_done=0, busy=0, digit buffer 0, all dirty bits 1, last-sent intensity 0, byte engine reset.
REQ-029 rst mid-frame SHALL force cs_n high on the next edge and restart the init sequence; the partial frame is discarded (LOAD rising on a partial frame is acceptable to the device only after init restart).

Structure
REQ-030 Register addresses (0x09-0x0C, 0x0F), init constants and FSM state encoding SHALL live in a shared package max7219_pkg.
REQ-031 SHALL instantiate exactly one sub-module, spi_master (byte engine), with rst tied to module rst.

Verification
REQ-032 Reset then idle inputs, intensity=4'h3 -> frames 0x0C01, 0x0F00, 0x0900, 0x0B07, 0x0A03, then 0x0100..0x0800 in order; init_done rises after 0x0A03.
REQ-033 After init, wr_en addr=2 data=8'h5A -> exactly one frame 0x035A; cs_n low 1 cycle before first sck; busy low afterwards.
REQ-034 Writes to digits 6 then 1 while a frame is active -> digit 1 (0x02xx) sent before digit 6 (0x07xx).
REQ-035 Write digit 0 = 8'h11 during its own frame, then = 8'h22 -> a later 0x0122 frame follows.
REQ-036 intensity changes 3->9 while digit 5 dirty -> 0x0A09 sent before 0x06xx.
REQ-037 rst asserted during WAIT_LO -> cs_n high next cycle; next frame observed is 0x0C01.
